// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-port signals around mem_port_arbiter.
// master = arbiter side, slave = requesters plus memory side.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              d_stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single memory port; data wins by default.
// Define MEM_ARB_FAIR_EN to force a fetch after STARVE_LIMIT data grants while fetch waits.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              sel_data_q, sel_data_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic grant_fetch;
    logic grant_data;
    logic starved;

`ifdef MEM_ARB_FAIR_EN
    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q, starve_d;

    assign starved = (starve_q == CNT_W'(STARVE_LIMIT));

    // Counter only tracks data grants that overtook a waiting fetch.
    always_comb begin
        starve_d = starve_q;
        if (!bus.if_req || grant_fetch) begin
            starve_d = '0;
        end else if (grant_data) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign starved = 1'b0;
`endif

    // Next-state and grant decision
    always_comb begin
        state_d     = state_q;
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        // A zero limit would make the fair build starve data instead.
        assert (STARVE_LIMIT != 0);
        case (state_q)
            IDLE: begin
                if (bus.if_req && (starved || !bus.d_req)) begin
                    grant_fetch = 1'b1;
                    state_d     = BUSY_IF;
                end else if (bus.d_req) begin
                    grant_data = 1'b1;
                    state_d    = BUSY_D;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (bus.mem_ready) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latches and read-data capture
    always_comb begin
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        sel_data_d = sel_data_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        if (grant_fetch) begin
            addr_d     = bus.if_addr;
            we_d       = 1'b0;
            wdata_d    = '0;
            sel_data_d = 1'b0;
        end else if (grant_data) begin
            addr_d     = bus.d_addr;
            we_d       = bus.d_we;
            wdata_d    = bus.d_wdata;
            sel_data_d = 1'b1;
        end

        if (state_q == BUSY_IF && bus.mem_ready) begin
            if_rdata_d = bus.mem_rdata;
        end
        if (state_q == BUSY_D && bus.mem_ready && !we_q) begin
            d_rdata_d = bus.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            sel_data_q <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            sel_data_q <= sel_data_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // FSM outputs
    always_comb begin
        bus.mem_req  = (state_q == BUSY_IF) || (state_q == BUSY_D);
        bus.if_valid = (state_q == DONE) && !sel_data_q;
        bus.d_valid  = (state_q == DONE) && sel_data_q;
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_stall  = bus.if_req & ~bus.if_valid;
    assign bus.d_stall   = bus.d_req & ~bus.d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; expected values computed by hand.
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;

    int unsigned n_checks;
    int unsigned n_fail;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [9:0]  grant_seq;
    int unsigned busy_cnt;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;

        #12;
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_if_valid", 32'(bus.if_valid), 32'd0);
        check("rst_d_valid", 32'(bus.d_valid), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_if_rdata", bus.if_rdata, 32'h0);
        check("rst_d_rdata", bus.d_rdata, 32'h0);
        rst_n = 1'b1;
        step();

        // Fetch alone, zero wait
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h40;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h8C010004;
        #1;
        check("f_stall_idle", 32'(bus.if_stall), 32'd1);
        step();
        check("f_busy_req", 32'(bus.mem_req), 32'd1);
        check("f_busy_addr", bus.mem_addr, 32'h40);
        check("f_busy_we", 32'(bus.mem_we), 32'd0);
        step();
        check("f_done_req", 32'(bus.mem_req), 32'd0);
        check("f_done_valid", 32'(bus.if_valid), 32'd1);
        check("f_done_rdata", bus.if_rdata, 32'h8C010004);
        check("f_done_stall", 32'(bus.if_stall), 32'd0);
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        step();
        check("f_idle_valid", 32'(bus.if_valid), 32'd0);

        // Simultaneous requests: data write first, then fetch
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h80;
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b1;
        bus.d_addr    = 32'h100;
        bus.d_wdata   = 32'hDEAD;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h11111111;
        step();
        check("s_d_req", 32'(bus.mem_req), 32'd1);
        check("s_d_we", 32'(bus.mem_we), 32'd1);
        check("s_d_addr", bus.mem_addr, 32'h100);
        check("s_d_wdata", bus.mem_wdata, 32'hDEAD);
        step();
        check("s_d_valid", 32'(bus.d_valid), 32'd1);
        check("s_if_valid_no", 32'(bus.if_valid), 32'd0);
        check("s_wr_rdata_kept", bus.d_rdata, 32'h0);
        check("s_if_stall", 32'(bus.if_stall), 32'd1);
        bus.d_req = 1'b0;
        step();
        check("s_idle_req", 32'(bus.mem_req), 32'd0);
        step();
        check("s_f_req", 32'(bus.mem_req), 32'd1);
        check("s_f_addr", bus.mem_addr, 32'h80);
        check("s_f_we", 32'(bus.mem_we), 32'd0);
        step();
        check("s_f_valid", 32'(bus.if_valid), 32'd1);
        check("s_f_rdata", bus.if_rdata, 32'h11111111);
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        step();

        // Data read with three wait cycles
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'h200;
        bus.mem_rdata = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) begin
            step();
            check("w_busy_req", 32'(bus.mem_req), 32'd1);
            check("w_busy_stall", 32'(bus.d_stall), 32'd1);
            check("w_busy_valid", 32'(bus.d_valid), 32'd0);
            if (i == 3) bus.mem_ready = 1'b1;
        end
        step();
        check("w_done_valid", 32'(bus.d_valid), 32'd1);
        check("w_done_rdata", bus.d_rdata, 32'hCAFEF00D);
        check("w_done_req", 32'(bus.mem_req), 32'd0);
        check("w_done_stall", 32'(bus.d_stall), 32'd0);
        bus.d_req = 1'b0;
        step();
        check("w_idle_valid", 32'(bus.d_valid), 32'd0);
        check("w_idle_ready_ign", 32'(bus.mem_req), 32'd0);
        step();
        check("w_idle2_req", 32'(bus.mem_req), 32'd0);
        bus.mem_ready = 1'b0;

        // Fetch request dropped mid-access still completes
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h60;
        step();
        check("x_busy_req", 32'(bus.mem_req), 32'd1);
        bus.if_req = 1'b0;
        step();
        check("x_busy2_req", 32'(bus.mem_req), 32'd1);
        check("x_busy2_stall", 32'(bus.if_stall), 32'd0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hA5A5;
        step();
        check("x_done_valid", 32'(bus.if_valid), 32'd1);
        check("x_done_rdata", bus.if_rdata, 32'hA5A5);
        bus.mem_ready = 1'b0;
        step();
        check("x_idle_valid", 32'(bus.if_valid), 32'd0);

        // Reset in the middle of a data access
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h300;
        bus.d_wdata = 32'h55;
        step();
        check("r_busy_req", 32'(bus.mem_req), 32'd1);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h44;
        #2;
        rst_n = 1'b0;
        #1;
        check("r_async_req", 32'(bus.mem_req), 32'd0);
        check("r_async_we", 32'(bus.mem_we), 32'd0);
        check("r_async_addr", bus.mem_addr, 32'h0);
        check("r_async_wdata", bus.mem_wdata, 32'h0);
        check("r_async_d_rdata", bus.d_rdata, 32'h0);
        check("r_async_if_rdata", bus.if_rdata, 32'h0);
        check("r_async_d_valid", 32'(bus.d_valid), 32'd0);
        bus.d_req = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        check("r_first_grant_req", 32'(bus.mem_req), 32'd1);
        check("r_first_grant_addr", bus.mem_addr, 32'h44);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h12345678;
        step();
        check("r_f_valid", 32'(bus.if_valid), 32'd1);
        check("r_f_rdata", bus.if_rdata, 32'h12345678);
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        step();

        // Both requesters held: record fetch/data order of ten accesses
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h500;
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b1;
        bus.d_addr    = 32'h600;
        bus.d_wdata   = 32'h77;
        bus.mem_ready = 1'b1;
        grant_seq     = '0;
        busy_cnt      = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.mem_req) begin
                busy_cnt++;
                grant_seq = {grant_seq[8:0], (bus.mem_addr == 32'h500)};
            end
        end
        bus.if_req    = 1'b0;
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b0;
        check("p_access_count", busy_cnt, 32'd10);
`ifdef MEM_ARB_FAIR_EN
        check("p_grant_order", 32'(grant_seq), 32'h021);
`else
        check("p_grant_order", 32'(grant_seq), 32'h000);
`endif
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
